// File: rtl/fwd_prop_unit.sv
// Forward-propagation engine: streams one weight row per pixel into NUM_OUT signed
// accumulators, then picks the winning output by a sequential signed argmax.
module fwd_prop_unit #(
  parameter  int IMG_SZ    = 784,
  parameter  int NUM_OUT   = 10,
  parameter  int W_WIDTH   = 8,
  parameter  int ACC_WIDTH = 18,
  localparam int AW        = $clog2(IMG_SZ),
  localparam int DW        = $clog2(NUM_OUT)
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         do_fp,
  input  logic [IMG_SZ-1:0]            image_in,
  output logic                         w_rd_en,
  output logic [AW-1:0]                w_addr,
  input  logic [NUM_OUT*W_WIDTH-1:0]   w_rd_data,
  output logic                         fp_done,
  output logic [NUM_OUT*ACC_WIDTH-1:0] scores,
  output logic [DW-1:0]                digit,
  output logic                         digit_valid,
  output logic                         busy
);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ARGMAX, DONE} state_t;

  state_t                       state_reg;
  logic [IMG_SZ-1:0]            img_reg;
  logic                         pix_reg;
  logic                         pix_vld_reg;
  logic [AW-1:0]                addr_reg;
  logic                         rd_en_reg;
  logic                         done_reg;
  logic                         valid_reg;
  logic [DW-1:0]                digit_reg;
  logic [DW-1:0]                best_idx_reg;
  logic [DW-1:0]                cmp_idx_reg;
  logic signed [ACC_WIDTH-1:0]  best_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg  [NUM_OUT];
  logic signed [ACC_WIDTH-1:0]  acc_next [NUM_OUT];

  logic                         clear_acc;
  logic                         add_row;
  logic signed [ACC_WIDTH-1:0]  cand;
  logic                         cand_better;
  logic [DW-1:0]                win_idx;
  logic signed [ACC_WIDTH-1:0]  win_val;

  assign clear_acc = (state_reg == IDLE) && do_fp;
  // The pipeline bit lines up with the row that the memory returns this cycle.
  assign add_row   = pix_vld_reg && pix_reg;

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      logic [W_WIDTH-1:0] w;
      assign w = w_rd_data[gi*W_WIDTH +: W_WIDTH];
      assign acc_next[gi] = add_row
          ? acc_reg[gi] + $signed({{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w})
          : acc_reg[gi];
      assign scores[gi*ACC_WIDTH +: ACC_WIDTH] = acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_OUT; i++) acc_reg[i] <= '0;
    end else if (clear_acc) begin
      for (int i = 0; i < NUM_OUT; i++) acc_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) acc_reg[i] <= acc_next[i];
    end
  end

  // Strictly-greater replacement keeps ties on the lowest index.
  assign cand        = acc_reg[cmp_idx_reg];
  assign cand_better = cand > best_reg;
  assign win_idx     = cand_better ? cmp_idx_reg : best_idx_reg;
  assign win_val     = cand_better ? cand : best_reg;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= IDLE;
      img_reg      <= '0;
      pix_reg      <= 1'b0;
      pix_vld_reg  <= 1'b0;
      addr_reg     <= '0;
      rd_en_reg    <= 1'b0;
      done_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      digit_reg    <= '0;
      best_idx_reg <= '0;
      cmp_idx_reg  <= '0;
      best_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (do_fp) begin
            img_reg   <= image_in;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            rd_en_reg <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (!do_fp) begin
            state_reg   <= IDLE;
            rd_en_reg   <= 1'b0;
            pix_vld_reg <= 1'b0;
          end else begin
            // Image is consumed LSB-first, so bit 0 is always pixel k.
            pix_reg     <= img_reg[0];
            img_reg     <= img_reg >> 1;
            pix_vld_reg <= 1'b1;
            if (addr_reg == AW'(IMG_SZ-1)) begin
              rd_en_reg <= 1'b0;
              state_reg <= DRAIN;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          pix_vld_reg <= 1'b0;
          if (!do_fp) begin
            state_reg <= IDLE;
          end else begin
            best_reg     <= acc_next[0];
            best_idx_reg <= '0;
            cmp_idx_reg  <= DW'(1);
            state_reg    <= ARGMAX;
          end
        end
        ARGMAX: begin
          if (!do_fp) begin
            state_reg <= IDLE;
          end else begin
            best_reg     <= win_val;
            best_idx_reg <= win_idx;
            if (cmp_idx_reg == DW'(NUM_OUT-1)) begin
              digit_reg <= win_idx;
              valid_reg <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              cmp_idx_reg <= cmp_idx_reg + 1'b1;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign w_rd_en     = rd_en_reg;
  assign w_addr      = addr_reg;
  assign fp_done     = done_reg;
  assign digit       = digit_reg;
  assign digit_valid = valid_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_fwd_prop_unit.sv
// Self-checking bench for fwd_prop_unit: directed scenarios plus randomized images,
// compared against a sum-of-weights / argmax reference model.
module tb_fwd_prop_unit;
  localparam int IMG_SZ    = 784;
  localparam int NUM_OUT   = 10;
  localparam int W_WIDTH   = 8;
  localparam int ACC_WIDTH = 18;
  localparam int AW        = 10;
  localparam int DW        = 4;

  logic                         clk = 1'b0;
  logic                         rst_l = 1'b0;
  logic                         do_fp = 1'b0;
  logic [IMG_SZ-1:0]            image_in = '0;
  logic                         w_rd_en;
  logic [AW-1:0]                w_addr;
  logic [NUM_OUT*W_WIDTH-1:0]   w_rd_data = '0;
  logic                         fp_done;
  logic [NUM_OUT*ACC_WIDTH-1:0] scores;
  logic [DW-1:0]                digit;
  logic                         digit_valid;
  logic                         busy;

  fwd_prop_unit #(
    .IMG_SZ(IMG_SZ), .NUM_OUT(NUM_OUT), .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .do_fp(do_fp), .image_in(image_in),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .fp_done(fp_done), .scores(scores), .digit(digit),
    .digit_valid(digit_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [NUM_OUT*W_WIDTH-1:0] mem [IMG_SZ];
  always @(posedge clk) if (w_rd_en) w_rd_data <= mem[w_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: fp_done pulses, read count, and address-sequence violations.
  int         done_cnt = 0;
  int         rd_cnt = 0;
  int         addr_err = 0;
  logic       prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (fp_done === 1'b1) done_cnt++;
    if (w_rd_en === 1'b1) begin
      rd_cnt++;
      if (prev_en ? (w_addr !== prev_addr + 1'b1) : (w_addr !== '0)) addr_err++;
    end
    prev_en   = w_rd_en;
    prev_addr = w_addr;
  end

  int checks = 0;
  int failures = 0;
  int c0, lat, d0, r0, e0;
  logic [IMG_SZ-1:0] cur_img;
  int exp_s [NUM_OUT];
  int exp_d;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compute_model(input logic [IMG_SZ-1:0] img);
    for (int o = 0; o < NUM_OUT; o++) exp_s[o] = 0;
    for (int k = 0; k < IMG_SZ; k++)
      if (img[k])
        for (int o = 0; o < NUM_OUT; o++)
          exp_s[o] += int'($signed(mem[k][o*W_WIDTH +: W_WIDTH]));
    exp_d = 0;
    for (int o = 1; o < NUM_OUT; o++) if (exp_s[o] > exp_s[exp_d]) exp_d = o;
  endtask

  task automatic check_result(input string tag);
    compute_model(cur_img);
    for (int o = 0; o < NUM_OUT; o++)
      check($sformatf("%s_score%0d", tag, o), $signed(scores[o*ACC_WIDTH +: ACC_WIDTH]), exp_s[o]);
    check({tag, "_digit"}, digit, exp_d);
    check({tag, "_valid"}, digit_valid, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fp_done"}, fp_done, 0);
    check({tag, "_w_rd_en"}, w_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, digit_valid, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_digit"}, digit, 0);
    check({tag, "_scores"}, (scores == '0) ? 1 : 0, 1);
  endtask

  task automatic rand_mem();
    for (int k = 0; k < IMG_SZ; k++)
      for (int o = 0; o < NUM_OUT; o++)
        mem[k][o*W_WIDTH +: W_WIDTH] = W_WIDTH'($urandom);
  endtask

  task automatic rand_img();
    for (int k = 0; k < IMG_SZ; k++) cur_img[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic start_run();
    @(negedge clk);
    do_fp = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fp_done === 1'b1) begin
        l = cyc - c0;
        break;
      end
    end
  endtask

  task automatic finish_run(input string tag);
    int l;
    wait_done(l);
    check({tag, "_latency"}, l, 795);
    do_fp = 1'b0;
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, fp_done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    for (int k = 0; k < IMG_SZ; k++) mem[k] = '0;
    cur_img = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_l = 1'b1;
    @(negedge clk);

    // All-zero image
    rand_mem();
    cur_img = '0;
    image_in = cur_img;
    d0 = done_cnt;
    start_run();
    @(negedge clk);
    check("zero_busy_start", busy, 1);
    finish_run("zero");
    check("zero_digit0", digit, 0);
    repeat (3) @(negedge clk);
    check("zero_one_done", done_cnt - d0, 1);
    $display("txn zero_image digit=%0d", digit);

    // Single pixel 5 with row 5 = o-3
    rand_mem();
    for (int o = 0; o < NUM_OUT; o++) mem[5][o*W_WIDTH +: W_WIDTH] = W_WIDTH'(o - 3);
    cur_img = '0;
    cur_img[5] = 1'b1;
    image_in = cur_img;
    r0 = rd_cnt;
    e0 = addr_err;
    start_run();
    finish_run("single");
    for (int o = 0; o < NUM_OUT; o++)
      check($sformatf("single_direct%0d", o), $signed(scores[o*ACC_WIDTH +: ACC_WIDTH]), o - 3);
    check("single_digit9", digit, 9);
    check("single_rd_cycles", rd_cnt - r0, IMG_SZ);
    check("single_addr_seq", addr_err - e0, 0);
    $display("txn single_pixel digit=%0d", digit);

    // Extremes: all pixels, out0=-128, out9=+127
    for (int k = 0; k < IMG_SZ; k++) begin
      mem[k] = '0;
      mem[k][0 +: W_WIDTH] = 8'h80;
      mem[k][9*W_WIDTH +: W_WIDTH] = 8'h7f;
    end
    cur_img = '1;
    image_in = cur_img;
    start_run();
    finish_run("extreme");
    check("extreme_s0", $signed(scores[0 +: ACC_WIDTH]), -100352);
    check("extreme_s9", $signed(scores[9*ACC_WIDTH +: ACC_WIDTH]), 99568);
    check("extreme_digit", digit, 9);
    $display("txn extremes digit=%0d", digit);

    // Tie between outputs 3 and 7 at 200
    rand_mem();
    for (int k = 0; k < 2; k++)
      for (int o = 0; o < NUM_OUT; o++)
        mem[k][o*W_WIDTH +: W_WIDTH] = (o == 3 || o == 7) ? 8'd100
                                       : W_WIDTH'($urandom_range(0, 227) - 128);
    cur_img = '0;
    cur_img[0] = 1'b1;
    cur_img[1] = 1'b1;
    image_in = cur_img;
    start_run();
    finish_run("tie");
    check("tie_s3", $signed(scores[3*ACC_WIDTH +: ACC_WIDTH]), 200);
    check("tie_digit", digit, 3);
    $display("txn tie digit=%0d", digit);

    // Random images, with image_in disturbed mid-run
    for (int r = 0; r < 2; r++) begin
      rand_mem();
      rand_img();
      image_in = cur_img;
      start_run();
      repeat (50) @(negedge clk);
      image_in = ~cur_img;
      finish_run($sformatf("rand%0d", r));
      $display("txn random%0d digit=%0d", r, digit);
    end

    // Abort at MAC cycle 100, then restart with a new image
    rand_mem();
    rand_img();
    image_in = cur_img;
    d0 = done_cnt;
    start_run();
    repeat (101) @(negedge clk);
    check("abort_addr100", w_addr, 100);
    check("abort_rd_en_before", w_rd_en, 1);
    do_fp = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_rd_en_after", w_rd_en, 0);
    repeat (900) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_valid0", digit_valid, 0);
    rand_img();
    image_in = cur_img;
    start_run();
    finish_run("restart");
    $display("txn abort_restart digit=%0d", digit);

    // Asynchronous reset during ARGMAX
    rand_mem();
    rand_img();
    image_in = cur_img;
    start_run();
    repeat (787) @(negedge clk);
    check("rst_busy_argmax", busy, 1);
    #2 rst_l = 1'b0;
    #1;
    check_reset_vals("midrst");
    do_fp = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    $display("txn reset_in_argmax busy=%0d", busy);

    // Back-to-back: do_fp held high across DONE
    rand_mem();
    rand_img();
    image_in = cur_img;
    d0 = done_cnt;
    start_run();
    wait_done(lat);
    check("b2b_lat1", lat, 795);
    check_result("b2b_a");
    rand_img();
    image_in = cur_img;
    c0 = cyc;
    @(negedge clk);
    check("b2b_idle_between", busy, 0);
    check("b2b_done_low", fp_done, 0);
    wait_done(lat);
    check("b2b_lat2", lat, 796);
    do_fp = 1'b0;
    check_result("b2b_b");
    repeat (3) @(negedge clk);
    check("b2b_two_done", done_cnt - d0, 2);
    $display("txn back_to_back digit=%0d", digit);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
